rc4_prga_decrypt: RTL and testbench
===================================

# rc4_prga_decrypt

Reader/modifier of the RC4 S-memory: once the S array has been initialised and key-scheduled, this block runs the RC4 pseudo-random generation phase. For each message byte it swaps S entries, forms the keystream byte, XORs it with the encrypted-message ROM, and writes the plaintext to the decrypted-message RAM. It sits downstream of the S-memory initialiser and key-schedule stages, sharing the same 256×8 S RAM port and the same `sig_start`/`t_done` handshake style.

## Interface
- `MSG_LEN`, 32: number of message bytes to decrypt (1..256).
- `MSG_AW`, 5: width of message ROM/RAM addresses (≥ clog2(MSG_LEN)).

- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- `sig_start`  in  1  start request, sampled in IDLE and DONE.
- `s_address`  out  8  S RAM address.
- `s_data`  out  8  S RAM write data.
- `s_wren`  out  1  S RAM write enable.
- `s_q`  in  8  S RAM read data (synchronous RAM, registered address, 1-cycle latency).
- `rom_address`  out  MSG_AW  encrypted-message ROM address.
- `rom_q`  in  8  ROM read data (same latency as S RAM).
- `dec_address`  out  MSG_AW  decrypted RAM address.
- `dec_data`  out  8  decrypted RAM write data.
- `dec_wren`  out  1  decrypted RAM write enable.
- `t_done`  out  1  high while in DONE.

## Operation
- All outputs are registered; values listed per state are driven during that state.
- Internal registers: `i`, `j` (8-bit, mod-256 wrap), `k` (MSG_AW), `si`, `sj` (8-bit).
- IDLE: wren's low, `t_done`=0. `sig_start`=1 → `i`←1, `j`←0, `k`←0, go RD_SI.
- Per byte, 9 states in fixed order:
  - RD_SI: `s_address`=i.
  - LT_SI: `s_address`=i; on exit `si`←`s_q`, `j`←`j+s_q` (mod 256).
  - RD_SJ: `s_address`=j.
  - LT_SJ: on exit `sj`←`s_q`.
  - WR_SI: `s_address`=i, `s_data`=sj, `s_wren`=1.
  - WR_SJ: `s_address`=j, `s_data`=si, `s_wren`=1.
  - RD_F: `s_wren`=0, `s_address`=si+sj (mod 256), `rom_address`=k.
  - LT_F: addresses held; on exit `f`←`s_q`, `e`←`rom_q`.
  - WR_DEC: `dec_address`=k, `dec_data`=f^e, `dec_wren`=1; on exit: if k==MSG_LEN-1 → DONE, else `k`←k+1, `i`←i+1, → RD_SI.
- DONE: `t_done`=1, all wren's 0; holds until `sig_start`=1, which restarts exactly as from IDLE (`t_done` drops next cycle).
- `sig_start` ignored in all other states.
- i==j: both swap writes hit same address; second write (si==sj) leaves S[i] unchanged. Required, not special-cased.
- `i` wraps 255→0 for MSG_LEN>255 (i reaches 0 when k=255).

## Timing
- Reset values: state IDLE; `s_address`, `s_data`, `s_wren`, `rom_address`, `dec_address`, `dec_data`, `dec_wren`, `t_done` all 0; `i`,`j`,`k`,`si`,`sj` 0.
- Reset mid-operation: immediate return to IDLE with reset values; S RAM and decrypted RAM keep partially updated contents (no rollback).
- Exactly 9 cycles per byte; DONE entered on the 9·MSG_LEN-th rising edge after the edge that samples `sig_start`.
- Exactly two `s_wren` cycles and one `dec_wren` cycle per byte; wren's never overlap.
- Read data sampled one full cycle after its address is first driven; address held stable across RD_x/LT_x.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle → all outputs 0 immediately, state IDLE; release, no activity without `sig_start`.
- Identity S (S[x]=x), ROM = 0x00.., MSG_LEN=4 → dec = {0x02, 0x05, 0x07, …}; after byte 2 S[2]=3, S[3]=5, S[5]=2 (byte 0 exercises i==j=1).
- Cycle count: MSG_LEN=4, 1-cycle `sig_start` pulse → `t_done` rises on the 36th edge after sampling; `dec_wren` high on edges 9, 18, 27, 36 windows only.
- `sig_start` held high throughout run → no restart until DONE; in DONE a new pulse clears `t_done`, reruns on mutated S, final dec matches software RC4 PRGA continuation from state i=1,j=0.
- Reset asserted during WR_SJ of byte 1 → IDLE, outputs 0; re-`sig_start` completes with `t_done`=1 after 9·MSG_LEN cycles.
- Full RC4 check: S RAM preloaded with key-scheduled array for key 0x000249, MSG_LEN=32 ROM → decrypted RAM equals software-model plaintext byte-for-byte.

Source files
------------

// File: rtl/rc4_prga_decrypt_if.sv
// Bundle between the RC4 PRGA decryptor and its S RAM, message ROM and decrypted RAM.
// The master view is the decryptor; the slave view is the memory/sequencer side.
interface rc4_prga_decrypt_if #(
    parameter int MSG_AW = 5
);
    logic              sig_start;
    logic [7:0]        s_address;
    logic [7:0]        s_data;
    logic              s_wren;
    logic [7:0]        s_q;
    logic [MSG_AW-1:0] rom_address;
    logic [7:0]        rom_q;
    logic [MSG_AW-1:0] dec_address;
    logic [7:0]        dec_data;
    logic              dec_wren;
    logic              t_done;

    modport master (
        input  sig_start, s_q, rom_q,
        output s_address, s_data, s_wren, rom_address,
               dec_address, dec_data, dec_wren, t_done
    );

    modport slave (
        output sig_start, s_q, rom_q,
        input  s_address, s_data, s_wren, rom_address,
               dec_address, dec_data, dec_wren, t_done
    );
endinterface

// File: rtl/rc4_prga_decrypt.sv
// RC4 pseudo-random generation phase: swaps S entries, forms the keystream byte and
// writes ROM ^ keystream into the decrypted RAM, nine cycles per message byte.
module rc4_prga_decrypt #(
    parameter int MSG_LEN = 32,
    parameter int MSG_AW  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    rc4_prga_decrypt_if.master    bus
);
    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_RD_SI  = 4'd1;
    localparam logic [3:0] ST_LT_SI  = 4'd2;
    localparam logic [3:0] ST_RD_SJ  = 4'd3;
    localparam logic [3:0] ST_LT_SJ  = 4'd4;
    localparam logic [3:0] ST_WR_SI  = 4'd5;
    localparam logic [3:0] ST_WR_SJ  = 4'd6;
    localparam logic [3:0] ST_RD_F   = 4'd7;
    localparam logic [3:0] ST_LT_F   = 4'd8;
    localparam logic [3:0] ST_WR_DEC = 4'd9;
    localparam logic [3:0] ST_DONE   = 4'd10;

    localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

    logic [3:0]        state;
    logic [7:0]        i;
    logic [7:0]        j;
    logic [MSG_AW-1:0] k;
    logic [7:0]        si;
    logic [7:0]        sj;

    // Every output is a register loaded with the value belonging to the state being
    // entered, so each branch below sets up the next state's outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            i               <= '0;
            j               <= '0;
            k               <= '0;
            si              <= '0;
            sj              <= '0;
            bus.s_address   <= '0;
            bus.s_data      <= '0;
            bus.s_wren      <= 1'b0;
            bus.rom_address <= '0;
            bus.dec_address <= '0;
            bus.dec_data    <= '0;
            bus.dec_wren    <= 1'b0;
            bus.t_done      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let later branches read the pre-edge
            // values of j, si, sj and k, and allow these defaults to be overridden.
            bus.s_wren   <= 1'b0;
            bus.dec_wren <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.sig_start) begin
                        i             <= 8'd1;
                        j             <= 8'd0;
                        k             <= '0;
                        bus.s_address <= 8'd1;
                        bus.t_done    <= 1'b0;
                        state         <= ST_RD_SI;
                    end
                end
                ST_RD_SI: state <= ST_LT_SI;
                ST_LT_SI: begin
                    si            <= bus.s_q;
                    j             <= j + bus.s_q;
                    bus.s_address <= j + bus.s_q;
                    state         <= ST_RD_SJ;
                end
                ST_RD_SJ: state <= ST_LT_SJ;
                ST_LT_SJ: begin
                    sj            <= bus.s_q;
                    bus.s_address <= i;
                    bus.s_data    <= bus.s_q;
                    bus.s_wren    <= 1'b1;
                    state         <= ST_WR_SI;
                end
                ST_WR_SI: begin
                    // When i == j this second write lands on the same word with the
                    // same value, which is exactly the RC4 no-op swap.
                    bus.s_address <= j;
                    bus.s_data    <= si;
                    bus.s_wren    <= 1'b1;
                    state         <= ST_WR_SJ;
                end
                ST_WR_SJ: begin
                    bus.s_address   <= si + sj;
                    bus.rom_address <= k;
                    state           <= ST_RD_F;
                end
                ST_RD_F: state <= ST_LT_F;
                ST_LT_F: begin
                    bus.dec_address <= k;
                    bus.dec_data    <= bus.s_q ^ bus.rom_q;
                    bus.dec_wren    <= 1'b1;
                    state           <= ST_WR_DEC;
                end
                ST_WR_DEC: begin
                    if (k == K_LAST) begin
                        bus.t_done <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        k             <= k + MSG_AW'(1);
                        i             <= i + 8'd1;
                        bus.s_address <= i + 8'd1;
                        state         <= ST_RD_SI;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Self-checking bench for rc4_prga_decrypt: memory models, an RC4 reference model
// feeding a scoreboard of expected decrypted writes, and cycle-exact handshake checks.
module tb_rc4_prga_decrypt;
    localparam int MSG_LEN = 32;
    localparam int MSG_AW  = 5;

    typedef struct packed {
        logic [MSG_AW-1:0] addr;
        logic [7:0]        data;
    } sb_entry_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [7:0] s_mem   [256];
    logic [7:0] s_img   [256];
    logic [7:0] model_s [256];
    logic [7:0] rom_mem [MSG_LEN];
    logic [7:0] dec_mem [MSG_LEN];
    bit         load_s;
    sb_entry_t  sb [$];

    rc4_prga_decrypt_if #(.MSG_AW(MSG_AW)) bus ();

    rc4_prga_decrypt #(.MSG_LEN(MSG_LEN), .MSG_AW(MSG_AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous S RAM with registered address; whole-image load for preloading.
    always @(posedge clk) begin
        if (load_s) s_mem <= s_img;
        else if (bus.s_wren) s_mem[bus.s_address] <= bus.s_data;
        bus.s_q <= s_mem[bus.s_address];
    end

    always @(posedge clk) bus.rom_q <= rom_mem[bus.rom_address];

    always @(posedge clk) if (bus.dec_wren) dec_mem[bus.dec_address] <= bus.dec_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: each decrypted write must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.dec_wren === 1'b1) begin
            sb_entry_t e;
            check("sb_pending", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("dec_write", {bus.dec_address, bus.dec_data}, {e.addr, e.data});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic load_image();
        load_s = 1'b1;
        @(posedge clk);
        #1 load_s = 1'b0;
    endtask

    task automatic load_identity();
        for (int x = 0; x < 256; x++) begin
            s_img[x]   = 8'(x);
            model_s[x] = 8'(x);
        end
        load_image();
    endtask

    // Reference PRGA from i=1, j=0 on model_s; pushes the expected writes.
    task automatic predict();
        logic [7:0] mi, mj, t, sum;
        sb_entry_t  e;
        mi = 8'd0;
        mj = 8'd0;
        for (int n = 0; n < MSG_LEN; n++) begin
            mi = mi + 8'd1;
            mj = mj + model_s[mi];
            t = model_s[mi];
            model_s[mi] = model_s[mj];
            model_s[mj] = t;
            sum = model_s[mi] + model_s[mj];
            e.addr = MSG_AW'(n);
            e.data = model_s[sum] ^ rom_mem[n];
            sb.push_back(e);
        end
    endtask

    task automatic run_msg(input bit hold_start, input string tag);
        int bad;
        int ph;
        logic [2:0] exp_flags;
        predict();
        @(negedge clk);
        bus.sig_start = 1'b1;
        @(posedge clk);
        bad = 0;
        for (int n = 0; n <= 9 * MSG_LEN; n++) begin
            @(negedge clk);
            ph = n % 9;
            exp_flags[2] = (n < 9 * MSG_LEN) && (ph == 4 || ph == 5);
            exp_flags[1] = (n < 9 * MSG_LEN) && (ph == 8);
            exp_flags[0] = (n == 9 * MSG_LEN);
            if ({bus.s_wren, bus.dec_wren, bus.t_done} !== exp_flags) bad++;
            if (!hold_start && n == 0) bus.sig_start = 1'b0;
            if (hold_start && n == 9 * MSG_LEN - 1) bus.sig_start = 1'b0;
            if (n < 9 * MSG_LEN) @(posedge clk);
        end
        check({tag, "_wren_timing"}, 64'(bad), 64'd0);
        check({tag, "_t_done"}, 64'(bus.t_done), 64'd1);
        check({tag, "_sb_drained"}, 64'(sb.size()), 64'd0);
        bad = 0;
        for (int x = 0; x < 256; x++) if (s_mem[x] !== model_s[x]) bad++;
        check({tag, "_s_final"}, 64'(bad), 64'd0);
    endtask

    initial begin
        int bad;
        checks        = 0;
        failures      = 0;
        load_s        = 1'b0;
        bus.sig_start = 1'b0;
        reset         = 1'b1;
        for (int x = 0; x < MSG_LEN; x++) rom_mem[x] = 8'h00;
        load_identity();
        @(negedge clk);
        check("reset_outputs", {bus.s_address, bus.s_data, bus.s_wren, bus.rom_address,
              bus.dec_address, bus.dec_data, bus.dec_wren, bus.t_done}, 64'd0);
        reset = 1'b0;

        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.s_wren || bus.dec_wren || bus.t_done || bus.s_address != 8'd0) bad++;
        end
        check("idle_quiet", 64'(bad), 64'd0);

        // Identity S with zero ROM: plaintext is the raw keystream.
        run_msg(1'b0, "identity");
        check("ident_dec0", 64'(dec_mem[0]), 64'h02);
        check("ident_dec1", 64'(dec_mem[1]), 64'h05);
        check("ident_dec2", 64'(dec_mem[2]), 64'h07);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.t_done !== 1'b1 || bus.s_wren || bus.dec_wren) bad++;
        end
        check("done_hold", 64'(bad), 64'd0);

        // Restart from DONE with sig_start held high, then a pulse, both on mutated S.
        run_msg(1'b1, "held_start");
        run_msg(1'b0, "rerun");

        // Abort during WR_SJ of byte 1: S[2] already took sj, S[3] never written.
        load_identity();
        predict();
        @(negedge clk);
        bus.sig_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.sig_start = 1'b0;
        repeat (14) @(negedge clk);
        check("abort_point", {bus.s_wren, bus.s_address, bus.s_data}, {1'b1, 8'd3, 8'd2});
        reset = 1'b1;
        #1;
        check("async_reset_outputs", {bus.s_address, bus.s_data, bus.s_wren, bus.rom_address,
              bus.dec_address, bus.dec_data, bus.dec_wren, bus.t_done}, 64'd0);
        check("abort_sb_left", 64'(sb.size()), 64'(MSG_LEN - 1));
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort_s2", 64'(s_mem[2]), 64'd3);
        check("abort_s3", 64'(s_mem[3]), 64'd3);
        for (int x = 0; x < 256; x++) model_s[x] = 8'(x);
        model_s[2] = 8'd3;
        run_msg(1'b0, "after_abort");

        // Full RC4: key-scheduled S for key 00 02 49 and a random ciphertext.
        begin
            logic [7:0] key [3];
            logic [7:0] kj, t;
            key[0] = 8'h00;
            key[1] = 8'h02;
            key[2] = 8'h49;
            for (int x = 0; x < 256; x++) s_img[x] = 8'(x);
            kj = 8'd0;
            for (int x = 0; x < 256; x++) begin
                kj = kj + s_img[x] + key[x % 3];
                t = s_img[x];
                s_img[x] = s_img[kj];
                s_img[kj] = t;
            end
            for (int x = 0; x < 256; x++) model_s[x] = s_img[x];
            for (int x = 0; x < MSG_LEN; x++) rom_mem[x] = 8'($urandom_range(0, 255));
            load_image();
        end
        run_msg(1'b0, "rc4_key");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
